// File: rtl/ctlb_refill_ctrl.sv
// ctlb_refill_ctrl: code-TLB miss/refill sequencer and full-TLB flush sweeper.
// Optional walk-response timeout: define CTLB_WALK_TIMEOUT_EN.

module ctlb_refill_ctrl #(
    parameter int VA_W      = 52,
    parameter int DATA_W    = 44,
    parameter int SETS_LOG2 = 6,
    parameter int TIMEOUT   = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              miss_valid,
    input  logic [VA_W-1:0]   miss_addr,
    input  logic              miss_nat,
    input  logic              flush_req,
    output logic              fetch_stall,
    output logic              walk_req,
    output logic [VA_W-1:0]   walk_addr,
    output logic              walk_nat,
    input  logic              walk_gnt,
    input  logic              walk_rsp_valid,
    input  logic [DATA_W-1:0] walk_rsp_data,
    input  logic              walk_rsp_fault,
    output logic              tlb_wen,
    output logic [DATA_W-1:0] tlb_wdata,
    output logic [VA_W-1:0]   tlb_addr,
    output logic              tlb_nat,
    output logic              tlb_init,
    output logic              fault_valid,
    output logic [VA_W-1:0]   fault_addr,
    output logic              flush_done
);

    // The walk timer is 8 bits wide, so the timeout must fit in it.
    if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
        $error("ctlb_refill_ctrl: TIMEOUT must be in 1..255");
    end
    if (SETS_LOG2 < 1 || SETS_LOG2 > VA_W) begin : g_bad_sets
        $error("ctlb_refill_ctrl: SETS_LOG2 must be in 1..VA_W");
    end

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_FILL,
        ST_FLUSH
    } state_e;

    localparam logic [SETS_LOG2-1:0] CNT_LAST = '1;

    state_e               state_q;
    logic [SETS_LOG2-1:0] count_q;
    logic [SETS_LOG2-1:0] count_d;
    logic                 flush_pend_q;

    logic                 fetch_stall_q;
    logic                 walk_req_q;
    logic [VA_W-1:0]      walk_addr_q;
    logic                 walk_nat_q;
    logic                 tlb_wen_q;
    logic [DATA_W-1:0]    tlb_wdata_q;
    logic [VA_W-1:0]      tlb_addr_q;
    logic                 tlb_nat_q;
    logic                 tlb_init_q;
    logic                 fault_valid_q;
    logic [VA_W-1:0]      fault_addr_q;
    logic                 flush_done_q;

    logic                 flush_hit;
    logic                 rsp_take;
    logic                 tmo_hit;
    logic                 walk_end;
    logic                 walk_ok;
    logic                 walk_bad;
    logic                 to_flush;

`ifdef CTLB_WALK_TIMEOUT_EN
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    logic [7:0] tmo_q;

    // Walk timer: zero outside WAIT, counts each WAIT cycle.
    always_ff @(posedge clk) begin
        if (rst || state_q != ST_WAIT) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_q + 8'd1;
        end
    end

    // A response on the deadline cycle still wins over the timeout.
    assign tmo_hit = (state_q == ST_WAIT) & ~walk_rsp_valid &
                     (tmo_q == TMO_LAST);
`else
    assign tmo_hit = 1'b0;
`endif

    assign count_d   = count_q + 1'b1;
    assign flush_hit = flush_req | flush_pend_q;

    // A response counts only while our walk is outstanding; a grant
    // and response in the same REQ cycle is taken at once.
    assign rsp_take = walk_rsp_valid &
                      ((state_q == ST_WAIT) |
                       ((state_q == ST_REQ) & walk_gnt));

    assign walk_end = rsp_take | tmo_hit;
    assign walk_ok  = rsp_take & ~walk_rsp_fault;
    assign walk_bad = (rsp_take & walk_rsp_fault) | tmo_hit;

    // Flush starts from IDLE, right after a FILL write, or when a
    // walk ends with a flush pending (its result is dropped).
    assign to_flush = flush_hit &
                      ((state_q == ST_IDLE) |
                       (state_q == ST_FILL) |
                       walk_end);

    // Sequencer state and all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_FLUSH;
            count_q       <= '0;
            flush_pend_q  <= 1'b0;
            fetch_stall_q <= 1'b1;
            walk_req_q    <= 1'b0;
            walk_addr_q   <= '0;
            walk_nat_q    <= 1'b0;
            tlb_wen_q     <= 1'b0;
            tlb_wdata_q   <= '0;
            tlb_addr_q    <= '0;
            tlb_nat_q     <= 1'b0;
            tlb_init_q    <= 1'b1;
            fault_valid_q <= 1'b0;
            fault_addr_q  <= '0;
            flush_done_q  <= 1'b0;
        end else begin
            tlb_wen_q     <= 1'b0;
            fault_valid_q <= 1'b0;
            flush_done_q  <= 1'b0;

            if (to_flush) begin
                state_q       <= ST_FLUSH;
                count_q       <= '0;
                flush_pend_q  <= 1'b0;
                fetch_stall_q <= 1'b1;
                walk_req_q    <= 1'b0;
                tlb_init_q    <= 1'b1;
                tlb_addr_q    <= '0;
            end else begin
                unique case (state_q)
                    ST_IDLE: begin
                        if (miss_valid) begin
                            state_q       <= ST_REQ;
                            fetch_stall_q <= 1'b1;
                            walk_req_q    <= 1'b1;
                            walk_addr_q   <= miss_addr;
                            walk_nat_q    <= miss_nat;
                        end
                    end
                    ST_REQ, ST_WAIT: begin
                        if (flush_req) begin
                            flush_pend_q <= 1'b1;
                        end
                        if (state_q == ST_REQ && walk_gnt) begin
                            walk_req_q <= 1'b0;
                            state_q    <= ST_WAIT;
                        end
                        if (walk_ok) begin
                            state_q     <= ST_FILL;
                            tlb_wen_q   <= 1'b1;
                            tlb_wdata_q <= walk_rsp_data;
                            tlb_addr_q  <= walk_addr_q;
                            tlb_nat_q   <= walk_nat_q;
                        end else if (walk_bad) begin
                            state_q       <= ST_IDLE;
                            fault_valid_q <= 1'b1;
                            fault_addr_q  <= walk_addr_q;
                            fetch_stall_q <= 1'b0;
                        end
                    end
                    ST_FILL: begin
                        state_q       <= ST_IDLE;
                        fetch_stall_q <= 1'b0;
                    end
                    ST_FLUSH: begin
                        if (count_q == CNT_LAST) begin
                            state_q       <= ST_IDLE;
                            count_q       <= '0;
                            tlb_init_q    <= 1'b0;
                            flush_done_q  <= 1'b1;
                            fetch_stall_q <= 1'b0;
                        end else begin
                            count_q    <= count_d;
                            tlb_addr_q <= VA_W'(count_d);
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign fetch_stall = fetch_stall_q;
    assign walk_req    = walk_req_q;
    assign walk_addr   = walk_addr_q;
    assign walk_nat    = walk_nat_q;
    assign tlb_wen     = tlb_wen_q;
    assign tlb_wdata   = tlb_wdata_q;
    assign tlb_addr    = tlb_addr_q;
    assign tlb_nat     = tlb_nat_q;
    assign tlb_init    = tlb_init_q;
    assign fault_valid = fault_valid_q;
    assign fault_addr  = fault_addr_q;
    assign flush_done  = flush_done_q;

endmodule

// File: tb/tb_ctlb_refill_ctrl.sv
// tb_ctlb_refill_ctrl: directed + random miss/flush traffic checked
// against a transaction-level expectation of writes, faults and sweeps.

module tb_ctlb_refill_ctrl;

`ifdef CTLB_WALK_TIMEOUT_EN
    localparam int TB_TMO = 10;
`else
    localparam int TB_TMO = 255;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        miss_valid;
    logic [51:0] miss_addr;
    logic        miss_nat;
    logic        flush_req;
    logic        fetch_stall;
    logic        walk_req;
    logic [51:0] walk_addr;
    logic        walk_nat;
    logic        walk_gnt;
    logic        walk_rsp_valid;
    logic [43:0] walk_rsp_data;
    logic        walk_rsp_fault;
    logic        tlb_wen;
    logic [43:0] tlb_wdata;
    logic [51:0] tlb_addr;
    logic        tlb_nat;
    logic        tlb_init;
    logic        fault_valid;
    logic [51:0] fault_addr;
    logic        flush_done;

    ctlb_refill_ctrl #(
        .VA_W     (52),
        .DATA_W   (44),
        .SETS_LOG2(6),
        .TIMEOUT  (TB_TMO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .miss_valid    (miss_valid),
        .miss_addr     (miss_addr),
        .miss_nat      (miss_nat),
        .flush_req     (flush_req),
        .fetch_stall   (fetch_stall),
        .walk_req      (walk_req),
        .walk_addr     (walk_addr),
        .walk_nat      (walk_nat),
        .walk_gnt      (walk_gnt),
        .walk_rsp_valid(walk_rsp_valid),
        .walk_rsp_data (walk_rsp_data),
        .walk_rsp_fault(walk_rsp_fault),
        .tlb_wen       (tlb_wen),
        .tlb_wdata     (tlb_wdata),
        .tlb_addr      (tlb_addr),
        .tlb_nat       (tlb_nat),
        .tlb_init      (tlb_init),
        .fault_valid   (fault_valid),
        .fault_addr    (fault_addr),
        .flush_done    (flush_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [51:0] a;
        logic [43:0] d;
        logic        n;
    } wr_t;

    wr_t         wq[$];
    logic [51:0] fq[$];
    logic [51:0] iq[$];
    int          n_done = 0;
    int          total  = 0;
    int          bad    = 0;

    // Event log sampled mid-cycle: writes, faults, sweep addresses.
    always @(negedge clk) begin
        if (!rst) begin
            if (tlb_wen) wq.push_back({tlb_addr, tlb_wdata, tlb_nat});
            if (fault_valid) fq.push_back(fault_addr);
            if (tlb_init) iq.push_back(tlb_addr);
            if (flush_done) n_done++;
        end
    end

    initial begin
        #5000000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [51:0] rnd_va();
        logic [63:0] t;
        t = {$urandom, $urandom};
        return t[51:0];
    endfunction

    function automatic logic [43:0] rnd_data();
        logic [63:0] t;
        t = {$urandom, $urandom};
        return t[43:0];
    endfunction

    task automatic wait_idle(input string tag);
        int k;
        k = 0;
        while (fetch_stall !== 1'b0 && k < 300) begin
            tick();
            k++;
        end
        chk({tag, " idle_bound"}, (k < 300), 1);
    endtask

    task automatic check_sweep(input string tag, input int i0);
        bit ok;
        ok = (iq.size() - i0 == 64);
        for (int k = 0; k < 64 && i0 + k < iq.size(); k++)
            if (iq[i0+k] !== 52'(k)) ok = 0;
        chk({tag, " sweep_seq"}, ok, 1);
    endtask

    // One miss: gd cycles before grant, response rd cycles after the
    // grant cycle (0 = with the grant). fl: 0 none, 1 flush in REQ,
    // 2 flush in WAIT, 3 flush on the cycle after the response.
    task automatic run_miss(input string tag, input logic [51:0] a,
                            input logic n, input int gd, input int rd,
                            input logic flt, input logic [43:0] d,
                            input int fl);
        int w0, f0, i0, d0;
        bit req_ok, exp_write, exp_fault, exp_sweep;
        w0 = wq.size();
        f0 = fq.size();
        i0 = iq.size();
        d0 = n_done;
        exp_sweep = (fl != 0);
        exp_write = (fl == 0 || fl == 3) && !flt;
        exp_fault = (fl == 0 || fl == 3) && flt;
        req_ok = 1;
        chk({tag, " start_idle"}, fetch_stall, 0);
        miss_valid = 1;
        miss_addr  = a;
        miss_nat   = n;
        tick();
        for (int r = 0; r <= gd; r++) begin
            if (!(walk_req === 1'b1 && walk_addr === a &&
                  walk_nat === n && fetch_stall === 1'b1)) req_ok = 0;
            miss_valid = 1'($urandom_range(0, 1));
            miss_addr  = rnd_va();
            miss_nat   = ~n;
            flush_req  = (fl == 1 && r == 0) ||
                         (fl == 2 && rd == 0 && r == gd);
            walk_gnt   = (r == gd);
            if (r == gd && rd == 0) begin
                walk_rsp_valid = 1;
                walk_rsp_data  = d;
                walk_rsp_fault = flt;
            end
            tick();
        end
        walk_gnt = 0;
        flush_req = 0;
        walk_rsp_valid = 0;
        for (int w = 1; w <= rd; w++) begin
            if (!(walk_req === 1'b0 && fetch_stall === 1'b1)) req_ok = 0;
            miss_valid = 1'($urandom_range(0, 1));
            miss_addr  = rnd_va();
            flush_req  = (fl == 2 && w == 1);
            if (w == rd) begin
                walk_rsp_valid = 1;
                walk_rsp_data  = d;
                walk_rsp_fault = flt;
            end
            tick();
        end
        miss_valid = 0;
        flush_req = 0;
        walk_rsp_valid = 0;
        walk_rsp_fault = 0;
        chk({tag, " walk_hold"}, req_ok, 1);
        if (exp_sweep && fl != 3) begin
            chk({tag, " discard_init"}, {tlb_init, tlb_wen, fault_valid},
                3'b100);
        end else if (flt) begin
            chk({tag, " fault_now"}, {fault_valid, tlb_wen}, 2'b10);
            chk({tag, " fault_addr"}, fault_addr, a);
        end else begin
            chk({tag, " wen_now"}, {tlb_wen, tlb_nat}, {1'b1, n});
            chk({tag, " wen_addr"}, tlb_addr, a);
            chk({tag, " wen_data"}, tlb_wdata, d);
        end
        if (fl == 3) flush_req = 1;
        tick();
        flush_req = 0;
        if (fl == 0 || fl == 3) begin
            chk({tag, " pulse_end"}, {tlb_wen, fault_valid}, 2'b00);
            chk({tag, " stall_after"}, fetch_stall, (fl == 3));
        end
        wait_idle(tag);
        tick();
        chk({tag, " n_write"}, wq.size() - w0, exp_write);
        if (exp_write && wq.size() > w0)
            chk({tag, " write_ent"}, wq[w0], {a, d, n});
        chk({tag, " n_fault"}, fq.size() - f0, exp_fault);
        if (exp_fault && fq.size() > f0)
            chk({tag, " fault_ent"}, fq[f0], a);
        chk({tag, " n_done"}, n_done - d0, exp_sweep);
        if (exp_sweep) check_sweep(tag, i0);
    endtask

    initial begin
        logic [51:0] a;
        logic [43:0] d;
        int          i0, d0, w0, f0, k;
        bit          ok;

        rst = 1;
        miss_valid = 0;
        miss_addr = '0;
        miss_nat = 0;
        flush_req = 0;
        walk_gnt = 0;
        walk_rsp_valid = 0;
        walk_rsp_data = '0;
        walk_rsp_fault = 0;
        tick();
        tick();
        tick();

        // Reset values
        chk("rst ctl", {walk_req, tlb_wen, fault_valid, flush_done},
            4'b0000);
        chk("rst init_stall", {tlb_init, fetch_stall}, 2'b11);
        chk("rst tlb_addr", tlb_addr, 0);
        chk("rst walk_addr", walk_addr, 0);
        chk("rst fault_addr", fault_addr, 0);
        chk("rst wdata", tlb_wdata, 0);

        // Power-on sweep; a flush_req mid-sweep must not restart it
        rst = 0;
        ok = 1;
        for (int i = 0; i < 64; i++) begin
            if (!(tlb_init === 1'b1 && tlb_addr === 52'(i) &&
                  flush_done === 1'b0 && fetch_stall === 1'b1)) ok = 0;
            flush_req = (i == 10);
            tick();
        end
        flush_req = 0;
        chk("boot sweep", ok, 1);
        chk("boot done", {flush_done, tlb_init, fetch_stall}, 3'b100);
        tick();
        chk("boot after", {flush_done, tlb_init, fetch_stall}, 3'b000);

        run_miss("tp_fill", 52'h12345, 0, 2, 5, 0, 44'hABC, 0);
        run_miss("tp_fault", rnd_va(), 1, 1, 3, 1, rnd_data(), 0);
        run_miss("tp_flwait", rnd_va(), 0, 1, 4, 0, rnd_data(), 2);
        run_miss("tp_flreq", rnd_va(), 1, 3, 2, 1, rnd_data(), 1);
        run_miss("tp_flfill", rnd_va(), 1, 0, 1, 0, rnd_data(), 3);
        run_miss("tp_samecyc", rnd_va(), 0, 0, 0, 0, rnd_data(), 0);

        // Flush and miss in the same IDLE cycle: sweep first
        a = rnd_va();
        d = rnd_data();
        i0 = iq.size();
        d0 = n_done;
        w0 = wq.size();
        miss_valid = 1;
        miss_addr = a;
        miss_nat = 1;
        flush_req = 1;
        tick();
        flush_req = 0;
        chk("flmiss init", {tlb_init, walk_req}, 2'b10);
        ok = 1;
        for (int i = 0; i < 64; i++) begin
            if (walk_req !== 1'b0) ok = 0;
            tick();
        end
        chk("flmiss noreq", ok, 1);
        chk("flmiss done", {flush_done, walk_req}, 2'b10);
        tick();
        miss_valid = 0;
        chk("flmiss req", {walk_req, walk_nat}, 2'b11);
        chk("flmiss addr", walk_addr, a);
        walk_gnt = 1;
        tick();
        walk_gnt = 0;
        walk_rsp_valid = 1;
        walk_rsp_data = d;
        tick();
        walk_rsp_valid = 0;
        chk("flmiss wen", tlb_wen, 1);
        wait_idle("flmiss");
        tick();
        chk("flmiss n_done", n_done - d0, 1);
        check_sweep("flmiss", i0);
        chk("flmiss n_write", wq.size() - w0, 1);
        if (wq.size() > w0) chk("flmiss write", wq[w0], {a, d, 1'b1});

        // No response for a long time
        a = rnd_va();
        d = rnd_data();
        w0 = wq.size();
        f0 = fq.size();
        miss_valid = 1;
        miss_addr = a;
        miss_nat = 0;
        tick();
        miss_valid = 0;
        walk_gnt = 1;
        tick();
        walk_gnt = 0;
`ifdef CTLB_WALK_TIMEOUT_EN
        k = 0;
        while (fault_valid !== 1'b1 && k < 50) begin
            tick();
            k++;
        end
        chk("tmo cycle", k, 10);
        chk("tmo addr", fault_addr, a);
        tick();
        chk("tmo pulse", fault_valid, 0);
        walk_rsp_valid = 1;
        walk_rsp_data = d;
        tick();
        walk_rsp_valid = 0;
        tick();
        tick();
        chk("tmo late", wq.size() - w0, 0);
        chk("tmo n_fault", fq.size() - f0, 1);
        chk("tmo idle", {fetch_stall, tlb_wen}, 2'b00);
`else
        ok = 1;
        for (k = 0; k < 300; k++) begin
            if (fault_valid !== 1'b0 || fetch_stall !== 1'b1 ||
                tlb_wen !== 1'b0 || walk_req !== 1'b0) ok = 0;
            tick();
        end
        chk("hold wait", ok, 1);
        walk_rsp_valid = 1;
        walk_rsp_data = d;
        tick();
        walk_rsp_valid = 0;
        chk("hold wen", tlb_wen, 1);
        chk("hold addr", tlb_addr, a);
        wait_idle("hold");
        tick();
        chk("hold n_write", wq.size() - w0, 1);
        chk("hold n_fault", fq.size() - f0, 0);
`endif

        // Random traffic
        for (int t = 0; t < 40; t++) begin
            int fr, fl;
            fr = $urandom_range(0, 5);
            fl = (fr <= 2) ? 0 : fr - 2;
            run_miss("rnd", rnd_va(), 1'($urandom_range(0, 1)),
                     $urandom_range(0, 3), $urandom_range(0, 5),
                     ($urandom_range(0, 3) == 0), rnd_data(), fl);
        end

        // Reset in the middle of a walk wins; the late response is dropped
        a = rnd_va();
        w0 = wq.size();
        d0 = n_done;
        miss_valid = 1;
        miss_addr = a;
        tick();
        miss_valid = 0;
        walk_gnt = 1;
        tick();
        walk_gnt = 0;
        tick();
        rst = 1;
        tick();
        rst = 0;
        chk("midrst state", {tlb_init, walk_req, fetch_stall, tlb_wen},
            4'b1010);
        chk("midrst addr", tlb_addr, 0);
        walk_rsp_valid = 1;
        walk_rsp_data = rnd_data();
        tick();
        walk_rsp_valid = 0;
        wait_idle("midrst");
        tick();
        chk("midrst n_write", wq.size() - w0, 0);
        chk("midrst n_done", n_done - d0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
